// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises fetch reads, store/load-buffer loads and ROB commits
// (stores and IO loads) onto a byte-wide single-port RAM/IO bus, one byte
// per cycle, and returns extended data with a one-cycle done pulse.
//
// Ports:
//   clk, rst (sync, active-low), rdy (global enable), in_rob_misbranch (flush)
//   in_fetcher_*  / out_fetcher_* : 32-bit instruction fetch request / result
//   in_slb_*      / out_slb_*     : 1/2/4-byte load request / extended result
//   in_rob_*      / out_rob_*     : committed store or IO load / IO load result
//   mem_din, mem_dout, mem_a, mem_wr : byte-wide RAM/IO bus
//   io_buffer_full : writes to IO_ADDR wait while this is high
module mem_ctrl #(
    parameter logic [31:0] IO_ADDR = 32'h30000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_rob_misbranch,
    input  logic        in_fetcher_ce,
    input  logic [31:0] in_fetcher_addr,
    output logic        out_fetcher_ce,
    output logic [31:0] out_fetcher_data,
    input  logic        in_slb_ce,
    input  logic [5:0]  in_slb_size,
    input  logic        in_slb_signed,
    input  logic [31:0] in_slb_addr,
    output logic        out_slb_ce,
    output logic [31:0] out_slb_data,
    input  logic        in_rob_ce,
    input  logic        in_rob_wr,
    input  logic [5:0]  in_rob_size,
    input  logic [31:0] in_rob_addr,
    input  logic [31:0] in_rob_data,
    output logic        out_rob_ce,
    output logic [31:0] out_rob_data,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, ROB_RD, STORE} state_t;

    state_t      state;
    logic        f_pend, s_pend, r_pend;
    logic [31:0] f_addr, s_addr, r_addr, r_data;
    logic [5:0]  s_size, r_size;
    logic        s_signed, r_wr;
    logic [31:0] cur_addr, cur_data, rbuf, mem_a_q;
    logic [5:0]  cur_size;
    logic        cur_signed, wr_q;
    logic [2:0]  idx;

    // Pending request or same-edge pulse, whichever is present
    logic        f_req, s_req, r_req, r_wr_e, s_signed_e;
    logic [31:0] f_addr_e, s_addr_e, r_addr_e, r_data_e;
    logic [5:0]  s_size_e, r_size_e;

    // Write datapath: byte about to be driven onto the bus
    logic [31:0] w_base, w_word, w_addr;
    logic [2:0]  w_idx;
    logic [7:0]  w_byte;
    logic        w_stall, w_last;

    // Read datapath
    logic [2:0]  rd_sel;
    logic [31:0] rd_full, rd_ext, rd_next_a;
    logic        rd_last;

    assign mem_a  = mem_a_q;
    assign mem_wr = wr_q & rdy;

    always_comb begin
        f_req      = (f_pend | in_fetcher_ce) & ~in_rob_misbranch;
        s_req      = (s_pend | in_slb_ce) & ~in_rob_misbranch;
        r_req      = r_pend | in_rob_ce;
        f_addr_e   = in_fetcher_ce ? in_fetcher_addr : f_addr;
        s_addr_e   = in_slb_ce ? in_slb_addr : s_addr;
        s_size_e   = in_slb_ce ? in_slb_size : s_size;
        s_signed_e = in_slb_ce ? in_slb_signed : s_signed;
        r_addr_e   = in_rob_ce ? in_rob_addr : r_addr;
        r_data_e   = in_rob_ce ? in_rob_data : r_data;
        r_size_e   = in_rob_ce ? in_rob_size : r_size;
        r_wr_e     = in_rob_ce ? in_rob_wr : r_wr;

        // In IDLE the first store byte comes straight from the ROB request;
        // in STORE, a byte already on the bus this cycle advances the index.
        if (state == IDLE) begin
            w_base = r_addr_e;
            w_word = r_data_e;
            w_idx  = 3'd0;
        end else begin
            w_base = cur_addr;
            w_word = cur_data;
            w_idx  = wr_q ? idx + 3'd1 : idx;
        end
        w_addr  = w_base + {29'b0, w_idx};
        w_byte  = w_word[{w_idx[1:0], 3'b0} +: 8];
        w_stall = (w_addr == IO_ADDR) && io_buffer_full;
        w_last  = ({3'b0, idx} + 6'd1) == cur_size;

        // Byte k arrives on mem_din when idx == k+2
        rd_sel  = idx - 3'd2;
        rd_full = rbuf;
        if (idx >= 3'd2)
            rd_full[{rd_sel[1:0], 3'b0} +: 8] = mem_din;
        rd_last   = {3'b0, idx} == (cur_size + 6'd1);
        rd_next_a = ({3'b0, idx} < cur_size) ? cur_addr + {29'b0, idx} : '0;

        case (cur_size)
            6'd1:    rd_ext = {{24{cur_signed & rd_full[7]}}, rd_full[7:0]};
            6'd2:    rd_ext = {{16{cur_signed & rd_full[15]}}, rd_full[15:0]};
            default: rd_ext = rd_full;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            f_pend           <= 1'b0;
            s_pend           <= 1'b0;
            r_pend           <= 1'b0;
            f_addr           <= '0;
            s_addr           <= '0;
            r_addr           <= '0;
            r_data           <= '0;
            s_size           <= '0;
            r_size           <= '0;
            s_signed         <= 1'b0;
            r_wr             <= 1'b0;
            cur_addr         <= '0;
            cur_data         <= '0;
            cur_size         <= '0;
            cur_signed       <= 1'b0;
            rbuf             <= '0;
            idx              <= '0;
            wr_q             <= 1'b0;
            mem_a_q          <= '0;
            mem_dout         <= '0;
            out_fetcher_ce   <= 1'b0;
            out_slb_ce       <= 1'b0;
            out_rob_ce       <= 1'b0;
            out_fetcher_data <= '0;
            out_slb_data     <= '0;
            out_rob_data     <= '0;
        end else if (rdy) begin
            out_fetcher_ce <= 1'b0;
            out_slb_ce     <= 1'b0;
            out_rob_ce     <= 1'b0;

            // Latch incoming pulses; IDLE's pick below clears what it consumes
            if (in_rob_ce) begin
                r_pend <= 1'b1;
                r_wr   <= in_rob_wr;
                r_size <= in_rob_size;
                r_addr <= in_rob_addr;
                r_data <= in_rob_data;
            end
            if (in_rob_misbranch) begin
                f_pend <= 1'b0;
                s_pend <= 1'b0;
            end else begin
                if (in_fetcher_ce) begin
                    f_pend <= 1'b1;
                    f_addr <= in_fetcher_addr;
                end
                if (in_slb_ce) begin
                    s_pend   <= 1'b1;
                    s_addr   <= in_slb_addr;
                    s_size   <= in_slb_size;
                    s_signed <= in_slb_signed;
                end
            end

            case (state)
                IDLE: begin
                    if (r_req) begin
                        r_pend     <= 1'b0;
                        cur_addr   <= r_addr_e;
                        cur_size   <= r_size_e;
                        cur_signed <= 1'b0;
                        cur_data   <= r_data_e;
                        if (r_wr_e) begin
                            state <= STORE;
                            idx   <= 3'd0;
                            if (w_stall) begin
                                wr_q     <= 1'b0;
                                mem_a_q  <= '0;
                                mem_dout <= '0;
                            end else begin
                                wr_q     <= 1'b1;
                                mem_a_q  <= w_addr;
                                mem_dout <= w_byte;
                            end
                        end else begin
                            state   <= ROB_RD;
                            mem_a_q <= r_addr_e;
                            idx     <= 3'd1;
                        end
                    end else if (s_req) begin
                        s_pend     <= 1'b0;
                        state      <= LOAD;
                        cur_addr   <= s_addr_e;
                        cur_size   <= s_size_e;
                        cur_signed <= s_signed_e;
                        mem_a_q    <= s_addr_e;
                        idx        <= 3'd1;
                    end else if (f_req) begin
                        f_pend     <= 1'b0;
                        state      <= FETCH;
                        cur_addr   <= f_addr_e;
                        cur_size   <= 6'd4;
                        cur_signed <= 1'b0;
                        mem_a_q    <= f_addr_e;
                        idx        <= 3'd1;
                    end
                end
                FETCH, LOAD, ROB_RD: begin
                    if (in_rob_misbranch && state != ROB_RD) begin
                        state   <= IDLE;
                        mem_a_q <= '0;
                        idx     <= 3'd0;
                    end else if (idx == 3'd0) begin
                        // Restart after a rdy stall: reissue byte 0
                        mem_a_q <= cur_addr;
                        idx     <= 3'd1;
                    end else begin
                        rbuf    <= rd_full;
                        mem_a_q <= rd_next_a;
                        if (rd_last) begin
                            state <= IDLE;
                            idx   <= 3'd0;
                            case (state)
                                FETCH: begin
                                    out_fetcher_ce   <= 1'b1;
                                    out_fetcher_data <= rd_ext;
                                end
                                LOAD: begin
                                    out_slb_ce   <= 1'b1;
                                    out_slb_data <= rd_ext;
                                end
                                default: begin
                                    out_rob_ce   <= 1'b1;
                                    out_rob_data <= rd_ext;
                                end
                            endcase
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                STORE: begin
                    if (wr_q && w_last) begin
                        state      <= IDLE;
                        idx        <= 3'd0;
                        wr_q       <= 1'b0;
                        mem_a_q    <= '0;
                        mem_dout   <= '0;
                        out_rob_ce <= 1'b1;
                    end else begin
                        if (wr_q)
                            idx <= idx + 3'd1;
                        if (w_stall) begin
                            wr_q     <= 1'b0;
                            mem_a_q  <= '0;
                            mem_dout <= '0;
                        end else begin
                            wr_q     <= 1'b1;
                            mem_a_q  <= w_addr;
                            mem_dout <= w_byte;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end else if (state == FETCH || state == LOAD || state == ROB_RD) begin
            // Read pipeline contents are stale after a stall; start over
            idx <= 3'd0;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        in_rob_misbranch = 1'b0;
    logic        in_fetcher_ce = 1'b0;
    logic [31:0] in_fetcher_addr = '0;
    logic        out_fetcher_ce;
    logic [31:0] out_fetcher_data;
    logic        in_slb_ce = 1'b0;
    logic [5:0]  in_slb_size = '0;
    logic        in_slb_signed = 1'b0;
    logic [31:0] in_slb_addr = '0;
    logic        out_slb_ce;
    logic [31:0] out_slb_data;
    logic        in_rob_ce = 1'b0;
    logic        in_rob_wr = 1'b0;
    logic [5:0]  in_rob_size = '0;
    logic [31:0] in_rob_addr = '0;
    logic [31:0] in_rob_data = '0;
    logic        out_rob_ce;
    logic [31:0] out_rob_data;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    int checks = 0;
    int failures = 0;

    mem_ctrl #(.IO_ADDR(32'h30000)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_rob_misbranch(in_rob_misbranch),
        .in_fetcher_ce(in_fetcher_ce), .in_fetcher_addr(in_fetcher_addr),
        .out_fetcher_ce(out_fetcher_ce), .out_fetcher_data(out_fetcher_data),
        .in_slb_ce(in_slb_ce), .in_slb_size(in_slb_size), .in_slb_signed(in_slb_signed),
        .in_slb_addr(in_slb_addr), .out_slb_ce(out_slb_ce), .out_slb_data(out_slb_data),
        .in_rob_ce(in_rob_ce), .in_rob_wr(in_rob_wr), .in_rob_size(in_rob_size),
        .in_rob_addr(in_rob_addr), .in_rob_data(in_rob_data),
        .out_rob_ce(out_rob_ce), .out_rob_data(out_rob_data),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM, 4 KiB aliased window
    logic [7:0] ram [0:4095];
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    // Bus write log and done-pulse monitors, sampled mid-cycle
    logic [31:0] wq_a[$];
    logic [7:0]  wq_d[$];
    int cyc = 0, f_cnt = 0, s_cnt = 0, r_cnt = 0, f_t = 0, s_t = 0, r_t = 0;
    always @(negedge clk) begin
        cyc++;
        if (mem_wr) begin
            wq_a.push_back(mem_a);
            wq_d.push_back(mem_dout);
        end
        if (out_fetcher_ce) begin f_cnt++; f_t = cyc; end
        if (out_slb_ce)     begin s_cnt++; s_t = cyc; end
        if (out_rob_ce)     begin r_cnt++; r_t = cyc; end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_req(input logic [31:0] a);
        in_fetcher_ce = 1'b1; in_fetcher_addr = a;
        tick;
        in_fetcher_ce = 1'b0;
    endtask

    task automatic slb_req(input logic [31:0] a, input logic [5:0] sz, input logic sg);
        in_slb_ce = 1'b1; in_slb_addr = a; in_slb_size = sz; in_slb_signed = sg;
        tick;
        in_slb_ce = 1'b0;
    endtask

    task automatic rob_req(input logic wr, input logic [31:0] a, input logic [5:0] sz,
                           input logic [31:0] d);
        in_rob_ce = 1'b1; in_rob_wr = wr; in_rob_addr = a; in_rob_size = sz; in_rob_data = d;
        tick;
        in_rob_ce = 1'b0;
    endtask

    // Ticks until the selected done output is high; returns cycles spent
    task automatic wait_done(input int which, input int limit, output int n);
        logic ce;
        n = 0;
        ce = (which == 0) ? out_fetcher_ce : (which == 1) ? out_slb_ce : out_rob_ce;
        while (!ce && n < limit) begin
            tick;
            n++;
            ce = (which == 0) ? out_fetcher_ce : (which == 1) ? out_slb_ce : out_rob_ce;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) tick;
        checks++;
        if ({mem_wr, mem_a, mem_dout} !== 41'b0) begin
            failures++;
            $display("FAIL reset_bus: wr=%0b a=%h dout=%h, want all 0", mem_wr, mem_a, mem_dout);
        end
        checks++;
        if ({out_fetcher_ce, out_slb_ce, out_rob_ce} !== 3'b0) begin
            failures++;
            $display("FAIL reset_ce: got %b want 000", {out_fetcher_ce, out_slb_ce, out_rob_ce});
        end
        checks++;
        if ({out_fetcher_data, out_slb_data, out_rob_data} !== 96'b0) begin
            failures++;
            $display("FAIL reset_data: %h %h %h want 0", out_fetcher_data, out_slb_data, out_rob_data);
        end
        rst = 1'b1;
        tick;
    endtask

    task automatic test_fetch;
        int n;
        wq_a.delete(); wq_d.delete();
        fetch_req(32'h100);
        wait_done(0, 20, n);
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL fetch_latency: got %0d want 5", n);
        end
        checks++;
        if (out_fetcher_data !== 32'h00000513) begin
            failures++;
            $display("FAIL fetch_data: got %h want 00000513", out_fetcher_data);
        end
        tick;
        checks++;
        if (wq_a.size() !== 0) begin
            failures++;
            $display("FAIL fetch_no_write: got %0d writes want 0", wq_a.size());
        end
    endtask

    task automatic test_load;
        logic [31:0] a [5]  = '{32'h200, 32'h200, 32'h202, 32'h202, 32'h200};
        logic [5:0]  sz [5] = '{6'd1, 6'd1, 6'd2, 6'd2, 6'd4};
        logic        sg [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ex [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001,
                                32'h00008001, 32'h80017F80};
        int n;
        for (int i = 0; i < 5; i++) begin
            slb_req(a[i], sz[i], sg[i]);
            wait_done(1, 20, n);
            checks++;
            if (n !== int'(sz[i]) + 1 || out_slb_data !== ex[i]) begin
                failures++;
                $display("FAIL load_%0d: lat=%0d data=%h want lat=%0d data=%h",
                         i, n, out_slb_data, int'(sz[i]) + 1, ex[i]);
            end
            tick;
        end
        // ROB IO load zero-extends regardless of the top bit
        rob_req(1'b0, 32'h202, 6'd2, 32'h0);
        wait_done(2, 20, n);
        checks++;
        if (n !== 3 || out_rob_data !== 32'h00008001) begin
            failures++;
            $display("FAIL rob_load: lat=%0d data=%h want lat=3 data=00008001", n, out_rob_data);
        end
        tick;
    endtask

    task automatic test_store;
        logic [31:0] ea [4] = '{32'h300, 32'h301, 32'h302, 32'h303};
        logic [7:0]  ed [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int n;
        wq_a.delete(); wq_d.delete();
        rob_req(1'b1, 32'h300, 6'd4, 32'hDEADBEEF);
        checks++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h300 || mem_dout !== 8'hEF) begin
            failures++;
            $display("FAIL store_first: wr=%0b a=%h d=%h want 1 300 ef", mem_wr, mem_a, mem_dout);
        end
        wait_done(2, 20, n);
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL store_latency: got %0d want 4", n);
        end
        checks++;
        if (wq_a.size() !== 4) begin
            failures++;
            $display("FAIL store_count: got %0d writes want 4", wq_a.size());
        end
        for (int i = 0; i < 4 && i < wq_a.size(); i++) begin
            checks++;
            if (wq_a[i] !== ea[i] || wq_d[i] !== ed[i]) begin
                failures++;
                $display("FAIL store_byte%0d: %h<=%h want %h<=%h", i, wq_a[i], wq_d[i], ea[i], ed[i]);
            end
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int f0, s0, r0, n;
        f0 = f_cnt; s0 = s_cnt; r0 = r_cnt;
        in_rob_ce = 1'b1; in_rob_wr = 1'b1; in_rob_addr = 32'h310; in_rob_size = 6'd1;
        in_rob_data = 32'h55;
        in_slb_ce = 1'b1; in_slb_addr = 32'h310; in_slb_size = 6'd1; in_slb_signed = 1'b0;
        in_fetcher_ce = 1'b1; in_fetcher_addr = 32'h100;
        tick;
        in_rob_ce = 1'b0; in_slb_ce = 1'b0; in_fetcher_ce = 1'b0;
        repeat (20) tick;
        checks++;
        if (f_cnt - f0 !== 1 || s_cnt - s0 !== 1 || r_cnt - r0 !== 1) begin
            failures++;
            $display("FAIL prio_counts: f=%0d s=%0d r=%0d want 1 1 1", f_cnt - f0, s_cnt - s0, r_cnt - r0);
        end
        checks++;
        if (!(r_t < s_t && s_t < f_t)) begin
            failures++;
            $display("FAIL prio_order: r=%0d s=%0d f=%0d want r<s<f", r_t, s_t, f_t);
        end
        checks++;
        if (out_slb_data !== 32'h55 || out_fetcher_data !== 32'h00000513) begin
            failures++;
            $display("FAIL prio_data: s=%h f=%h want 00000055 00000513", out_slb_data, out_fetcher_data);
        end
        // New fetch pulsed on the edge that completes the previous one
        fetch_req(32'h100);
        repeat (4) tick;
        in_fetcher_ce = 1'b1; in_fetcher_addr = 32'h104;
        tick;
        in_fetcher_ce = 1'b0;
        checks++;
        if (out_fetcher_ce !== 1'b1 || out_fetcher_data !== 32'h00000513) begin
            failures++;
            $display("FAIL b2b_first: ce=%0b data=%h want 1 00000513", out_fetcher_ce, out_fetcher_data);
        end
        tick;
        wait_done(0, 20, n);
        checks++;
        if (n >= 20 || out_fetcher_data !== 32'h00100093) begin
            failures++;
            $display("FAIL b2b_second: wait=%0d data=%h want data 00100093", n, out_fetcher_data);
        end
        tick;
    endtask

    task automatic test_misbranch;
        int f0, n;
        f0 = f_cnt;
        fetch_req(32'h100);
        tick;
        in_rob_misbranch = 1'b1;
        tick;
        in_rob_misbranch = 1'b0;
        repeat (10) tick;
        checks++;
        if (f_cnt !== f0) begin
            failures++;
            $display("FAIL mb_fetch_abort: got %0d done pulses want 0", f_cnt - f0);
        end
        slb_req(32'h200, 6'd1, 1'b0);
        wait_done(1, 20, n);
        checks++;
        if (n !== 2 || out_slb_data !== 32'h80) begin
            failures++;
            $display("FAIL mb_slb_after: lat=%0d data=%h want 2 00000080", n, out_slb_data);
        end
        tick;
        wq_a.delete(); wq_d.delete();
        rob_req(1'b1, 32'h320, 6'd4, 32'h11223344);
        tick;
        in_rob_misbranch = 1'b1;
        tick;
        in_rob_misbranch = 1'b0;
        wait_done(2, 20, n);
        checks++;
        if (n >= 20 || wq_a.size() !== 4) begin
            failures++;
            $display("FAIL mb_store: wait=%0d writes=%0d want done and 4 writes", n, wq_a.size());
        end
        checks++;
        if ({ram[12'h323], ram[12'h322], ram[12'h321], ram[12'h320]} !== 32'h11223344) begin
            failures++;
            $display("FAIL mb_store_data: got %h want 11223344",
                     {ram[12'h323], ram[12'h322], ram[12'h321], ram[12'h320]});
        end
        tick;
    endtask

    task automatic test_io_stall;
        int n;
        wq_a.delete(); wq_d.delete();
        io_buffer_full = 1'b1;
        rob_req(1'b1, 32'h30000, 6'd1, 32'h41);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_wr !== 1'b0) begin
                failures++;
                $display("FAIL io_stall_c%0d: mem_wr=%0b want 0", i, mem_wr);
            end
            if (i < 2) tick;
        end
        io_buffer_full = 1'b0;
        tick;
        checks++;
        if (mem_wr !== 1'b1 || mem_dout !== 8'h41 || mem_a !== 32'h30000) begin
            failures++;
            $display("FAIL io_write: wr=%0b a=%h d=%h want 1 30000 41", mem_wr, mem_a, mem_dout);
        end
        wait_done(2, 20, n);
        tick;
        checks++;
        if (wq_a.size() !== 1 || n >= 20) begin
            failures++;
            $display("FAIL io_single: writes=%0d wait=%0d want 1 write and done", wq_a.size(), n);
        end
    endtask

    task automatic test_rdy_stall;
        int s0, n;
        s0 = s_cnt;
        slb_req(32'h200, 6'd4, 1'b0);
        tick;
        rdy = 1'b0;
        checks++;
        if (mem_wr !== 1'b0) begin
            failures++;
            $display("FAIL rdy_wr: mem_wr=%0b want 0", mem_wr);
        end
        repeat (2) tick;
        rdy = 1'b1;
        wait_done(1, 30, n);
        checks++;
        if (n >= 30 || out_slb_data !== 32'h80017F80) begin
            failures++;
            $display("FAIL rdy_data: wait=%0d data=%h want 80017f80", n, out_slb_data);
        end
        repeat (3) tick;
        checks++;
        if (s_cnt - s0 !== 1) begin
            failures++;
            $display("FAIL rdy_pulses: got %0d want 1", s_cnt - s0);
        end
    endtask

    task automatic test_reset_mid_read;
        int f0;
        f0 = f_cnt;
        fetch_req(32'h100);
        repeat (2) tick;
        rst = 1'b0;
        tick;
        checks++;
        if (mem_a !== 32'h0 || mem_wr !== 1'b0 || out_fetcher_ce !== 1'b0 ||
            out_slb_data !== 32'h0 || out_fetcher_data !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid: a=%h wr=%0b ce=%0b sd=%h fd=%h want all 0",
                     mem_a, mem_wr, out_fetcher_ce, out_slb_data, out_fetcher_data);
        end
        rst = 1'b1;
        repeat (10) tick;
        checks++;
        if (f_cnt !== f0) begin
            failures++;
            $display("FAIL rst_no_done: got %0d pulses want 0", f_cnt - f0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
        ram[12'h104] = 8'h93; ram[12'h105] = 8'h00; ram[12'h106] = 8'h10; ram[12'h107] = 8'h00;
        ram[12'h200] = 8'h80; ram[12'h201] = 8'h7F; ram[12'h202] = 8'h01; ram[12'h203] = 8'h80;
        test_reset;
        test_fetch;
        test_load;
        test_store;
        test_back_to_back;
        test_misbranch;
        test_io_stall;
        test_rdy_stall;
        test_reset_mid_read;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
